// File: rtl/spi_pkg.sv
// Shared definitions for the SPI master: state encoding, mode bit positions,
// mode constants and per-byte edge count.
package spi_pkg;

  // Controller states. WAIT keeps cs_n low between bytes of a burst.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_SHIFT = 3'd2,
    ST_WAIT  = 3'd3,
    ST_HOLD  = 3'd4,
    ST_GAP   = 3'd5
  } spi_state_t;

  // Bit positions inside the 2-bit mode word.
  localparam int CPOL_BIT = 1;
  localparam int CPHA_BIT = 0;

  // The four standard SPI modes as {CPOL, CPHA}.
  localparam logic [1:0] MODE0 = 2'b00;
  localparam logic [1:0] MODE1 = 2'b01;
  localparam logic [1:0] MODE2 = 2'b10;
  localparam logic [1:0] MODE3 = 2'b11;

  // Every byte is framed by exactly this many sclk transitions.
  localparam logic [4:0] EDGES_PER_BYTE = 5'd16;

endpackage

// File: rtl/spi_sclk_gen.sv
// Half-period timer for the SPI master. While run is high it emits a one-cycle
// strobe every half_div clocks and tracks which sclk edge (1..16) the next
// strobe represents. Dropping run parks the timer so the first strobe after
// re-entry lands exactly half_div cycles later.
module spi_sclk_gen
  import spi_pkg::*;
#(
  parameter int half_div = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       run,
  output logic       edge_stb,
  output logic [4:0] edge_idx,
  output logic       edges_done
);

  localparam int CW = (half_div > 2) ? $clog2(half_div) : 1;
  localparam logic [CW-1:0] RELOAD = CW'(half_div - 1);

  logic [CW-1:0] cnt;
  logic [4:0]    edge_cnt;

  assign edge_stb   = run && (cnt == '0);
  assign edge_idx   = edge_cnt + 5'd1;
  assign edges_done = (edge_cnt == EDGES_PER_BYTE);

  // Down-counter with reload; edge count saturates at 16 so HOLD/GAP can keep
  // reusing the strobe without wrapping the index.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt      <= RELOAD;
      edge_cnt <= '0;
    end else if (!run) begin
      cnt      <= RELOAD;
      edge_cnt <= '0;
    end else if (cnt == '0) begin
      cnt <= RELOAD;
      if (edge_cnt != EDGES_PER_BYTE) edge_cnt <= edge_cnt + 5'd1;
    end else begin
      cnt <= cnt - 1'b1;
    end
  end

endmodule

// File: rtl/spi_master_driver.sv
// Full-duplex single-chip-select SPI master. Takes bytes over ready/valid,
// drives cs_n/sclk/mosi from registers, and returns each received byte with a
// one-cycle rx_valid strobe. Bytes sent with tx_last=0 keep cs_n asserted so
// the next byte follows in the same frame.
module spi_master_driver
  import spi_pkg::*;
#(
  parameter logic [1:0] mode     = MODE0,
  parameter int         half_div = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_last,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       sclk,
  output logic       mosi,
  input  logic       miso,
  output logic       cs_n
);

  localparam logic CPOL = mode[CPOL_BIT];
  localparam logic CPHA = mode[CPHA_BIT];

  spi_state_t state, state_nxt;

  logic [7:0] tx_sh;
  logic [7:0] rx_sh;
  logic       last_q;

  logic       run;
  logic       edge_stb;
  logic [4:0] edge_idx;
  logic       edges_done;
  logic       accept;
  logic       sclk_edge;
  logic       lead;
  logic       sample;
  logic       drive;

  // The timer runs whenever a half-period has to be measured; IDLE and WAIT
  // park it so SETUP always starts from a full half-period.
  assign run = (state == ST_SETUP) || (state == ST_SHIFT) ||
               (state == ST_HOLD)  || (state == ST_GAP);

  spi_sclk_gen #(.half_div(half_div)) u_sclk_gen (
    .clk        (clk),
    .rst        (rst),
    .run        (run),
    .edge_stb   (edge_stb),
    .edge_idx   (edge_idx),
    .edges_done (edges_done)
  );

  assign accept = tx_valid && tx_ready;

  // Edge 1 is the strobe that ends SETUP; edges 2..16 come from SHIFT.
  assign sclk_edge = edge_stb && !edges_done &&
                     ((state == ST_SETUP) || (state == ST_SHIFT));
  // Odd edges move sclk away from its idle level.
  assign lead   = edge_idx[0];
  assign sample = sclk_edge && (CPHA ? !lead : lead);
  // CPHA=0 launches bits on trailing edges but edge 16 closes the byte;
  // CPHA=1 launches on every leading edge, edge 1 re-driving bit 7.
  assign drive  = sclk_edge && (CPHA ? lead : (!lead && (edge_idx != EDGES_PER_BYTE)));

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic; tx_ready depends on state only.
  always_comb begin
    state_nxt = state;
    tx_ready  = 1'b0;
    case (state)
      ST_IDLE: begin
        tx_ready = 1'b1;
        if (tx_valid) state_nxt = ST_SETUP;
      end
      ST_SETUP: if (edge_stb)   state_nxt = ST_SHIFT;
      ST_SHIFT: if (edges_done) state_nxt = last_q ? ST_HOLD : ST_WAIT;
      ST_WAIT: begin
        tx_ready = 1'b1;
        if (tx_valid) state_nxt = ST_SETUP;
      end
      // The timer keeps running from edge 16, so HOLD ends one half-period
      // after the final edge.
      ST_HOLD:  if (edge_stb) state_nxt = ST_GAP;
      ST_GAP:   if (edge_stb) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Shift registers, pin registers and receive strobe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cs_n     <= 1'b1;
      sclk     <= CPOL;
      mosi     <= 1'b0;
      rx_data  <= 8'h00;
      rx_valid <= 1'b0;
      tx_sh    <= 8'h00;
      rx_sh    <= 8'h00;
      last_q   <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      if (accept) begin
        tx_sh  <= tx_data;
        last_q <= tx_last;
        mosi   <= tx_data[7];
        cs_n   <= 1'b0;
      end
      if (sclk_edge) sclk <= ~sclk;
      // miso is taken as it stands at the clock edge that moves sclk.
      if (sample) rx_sh <= {rx_sh[6:0], miso};
      if (drive) begin
        mosi  <= CPHA ? tx_sh[7] : tx_sh[6];
        tx_sh <= {tx_sh[6:0], 1'b0};
      end
      if ((state == ST_SHIFT) && edges_done) begin
        rx_valid <= 1'b1;
        rx_data  <= rx_sh;
      end
      if ((state == ST_HOLD) && edge_stb) cs_n <= 1'b1;
      if ((state == ST_GAP) && edge_stb)  mosi <= 1'b0;
    end
  end

endmodule

// File: tb/tb_spi_master_driver.sv
// Bench for spi_master_driver: one instance per SPI mode (half_div=4), a
// behavioural slave per instance, and a cycle-accurate expectation computed
// from the frame timing (edge k lands k half-periods after cs_n falls).
module tb_spi_master_driver;

  localparam int HD = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] tx_data;
  logic       tx_last;
  logic [3:0] tx_valid;
  logic [3:0] miso;
  wire  [3:0] tx_ready;
  wire  [3:0] rx_valid;
  wire  [3:0] sclk;
  wire  [3:0] mosi;
  wire  [3:0] cs_n;
  wire  [7:0] rx_data [4];

  // Bytes each slave returns, indexed by position within the burst.
  logic [7:0] sl_byte [4][4];
  int         ecnt [4];
  logic [3:0] prev_sclk;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    spi_master_driver #(.mode(2'(g)), .half_div(HD)) u_dut (
      .clk      (clk),
      .rst      (rst),
      .tx_data  (tx_data),
      .tx_last  (tx_last),
      .tx_valid (tx_valid[g]),
      .tx_ready (tx_ready[g]),
      .rx_data  (rx_data[g]),
      .rx_valid (rx_valid[g]),
      .sclk     (sclk[g]),
      .mosi     (mosi[g]),
      .miso     (miso[g]),
      .cs_n     (cs_n[g])
    );
  end

  // Slave model: counts sclk transitions while selected and presents the bit
  // the master should capture next (CPHA=0: new bit after each even edge;
  // CPHA=1: new bit after each odd edge).
  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      int w, b, bi;
      if (cs_n[i] !== 1'b0) ecnt[i] = 0;
      else if (sclk[i] !== prev_sclk[i]) ecnt[i] = ecnt[i] + 1;
      prev_sclk[i] = sclk[i];
      w = ecnt[i] % 16;
      b = (ecnt[i] / 16) % 4;
      if (i[0]) bi = (w == 0) ? 0 : (w - 1) / 2;
      else      bi = w / 2;
      if (bi > 7) bi = 7;
      miso[i] = sl_byte[i][b][7-bi];
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One byte on instance g. Called at a negedge; returns at a negedge with
  // tx_ready high (WAIT for a non-last byte, IDLE after a last byte).
  task automatic run_xfer(input int g, input logic [7:0] d, input logic last,
                          input int bidx, input bit hold);
    int         wait_n, nend, e, bi;
    logic       cpol, cpha;
    logic [7:0] expb;
    string      p;
    cpol = g[1];
    cpha = g[0];
    expb = sl_byte[g][bidx];
    tx_data = d;
    tx_last = last;
    tx_valid[g] = 1'b1;
    wait_n = 0;
    while (tx_ready[g] !== 1'b1 && wait_n < 200) begin
      @(negedge clk);
      wait_n++;
    end
    chk($sformatf("m%0d ready_wait", g), 32'(wait_n < 200), 32'd1);
    if (wait_n >= 200) begin
      tx_valid[g] = 1'b0;
      return;
    end
    nend = last ? 18*HD + 1 : 16*HD + 2;
    for (int n = 1; n <= nend; n++) begin
      @(negedge clk);
      if (n == 1) begin
        if (hold) begin
          tx_data = ~d;
          tx_last = ~last;
        end else begin
          tx_valid[g] = 1'b0;
        end
      end
      p = $sformatf("m%0d b%0d n%0d", g, bidx, n);
      e = (n - 1) / HD;
      if (e > 16) e = 16;
      if (cpha) bi = (e == 0) ? 0 : (e - 1) / 2;
      else      bi = e / 2;
      if (bi > 7) bi = 7;
      chk({p, " cs_n"}, 32'(cs_n[g]), 32'(last && n > 17*HD));
      chk({p, " sclk"}, 32'(sclk[g]), 32'(cpol ^ e[0]));
      if (n <= 16*HD + 2) chk({p, " mosi"}, 32'(mosi[g]), 32'(d[7-bi]));
      chk({p, " rx_valid"}, 32'(rx_valid[g]), 32'(n == 16*HD + 2));
      chk({p, " tx_ready"}, 32'(tx_ready[g]),
          32'((n == 16*HD + 2 && !last) || n == 18*HD + 1));
      if (n >= 16*HD + 2) chk({p, " rx_data"}, 32'(rx_data[g]), 32'(expb));
      if (n == 16*HD + 2) chk({p, " edges"}, 32'(ecnt[g]), 32'(16*(bidx + 1)));
      if (n == 18*HD + 1) chk({p, " mosi_idle"}, 32'(mosi[g]), 32'd0);
    end
    if (hold) tx_valid[g] = 1'b0;
  endtask

  initial begin
    int rg, nb;
    rst = 1'b1;
    tx_valid = '0;
    tx_data = 8'h00;
    tx_last = 1'b0;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) sl_byte[i][j] = 8'h00;
    repeat (3) @(negedge clk);

    // Reset values, held in reset and just after release.
    for (int g = 0; g < 4; g++) begin
      chk($sformatf("rst m%0d cs_n", g), 32'(cs_n[g]), 32'd1);
      chk($sformatf("rst m%0d sclk", g), 32'(sclk[g]), 32'(g[1]));
      chk($sformatf("rst m%0d mosi", g), 32'(mosi[g]), 32'd0);
      chk($sformatf("rst m%0d rx_data", g), 32'(rx_data[g]), 32'd0);
      chk($sformatf("rst m%0d rx_valid", g), 32'(rx_valid[g]), 32'd0);
      chk($sformatf("rst m%0d tx_ready", g), 32'(tx_ready[g]), 32'd1);
    end
    rst = 1'b0;
    @(negedge clk);
    for (int g = 0; g < 4; g++)
      chk($sformatf("post_rst m%0d tx_ready", g), 32'(tx_ready[g]), 32'd1);

    // Single bytes in each mode.
    sl_byte[0][0] = 8'h3C; run_xfer(0, 8'hA5, 1'b1, 0, 1'b0);
    sl_byte[3][0] = 8'hC3; run_xfer(3, 8'h5A, 1'b1, 0, 1'b0);
    sl_byte[1][0] = 8'h81; run_xfer(1, 8'hFF, 1'b1, 0, 1'b0);
    sl_byte[2][0] = 8'h81; run_xfer(2, 8'h00, 1'b1, 0, 1'b0);

    // Two-byte burst under one chip select, zero-bubble second accept.
    sl_byte[0][0] = 8'hAA;
    sl_byte[0][1] = 8'h55;
    run_xfer(0, 8'h11, 1'b0, 0, 1'b0);
    run_xfer(0, 8'h22, 1'b1, 1, 1'b0);

    // tx_valid held with changing data: only the accepted byte is used.
    sl_byte[2][0] = 8'h96;
    run_xfer(2, 8'h6B, 1'b1, 0, 1'b1);

    // Reset at sclk edge 7 of a mode 2 transfer.
    sl_byte[2][0] = 8'hE7;
    chk("rstmid ready", 32'(tx_ready[2]), 32'd1);
    tx_data = 8'h99;
    tx_last = 1'b1;
    tx_valid[2] = 1'b1;
    @(negedge clk);
    tx_valid[2] = 1'b0;
    repeat (7*HD) @(negedge clk);
    chk("rstmid edge7 sclk", 32'(sclk[2]), 32'd0);
    chk("rstmid edge7 cs_n", 32'(cs_n[2]), 32'd0);
    rst = 1'b1;
    #1;
    chk("rstmid cs_n", 32'(cs_n[2]), 32'd1);
    chk("rstmid sclk", 32'(sclk[2]), 32'd1);
    chk("rstmid mosi", 32'(mosi[2]), 32'd0);
    chk("rstmid tx_ready", 32'(tx_ready[2]), 32'd1);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    for (int n = 0; n < 20*HD; n++) begin
      @(negedge clk);
      chk($sformatf("rstmid quiet n%0d rx_valid", n), 32'(rx_valid[2]), 32'd0);
      chk($sformatf("rstmid quiet n%0d cs_n", n), 32'(cs_n[2]), 32'd1);
    end
    run_xfer(2, 8'h3C, 1'b1, 0, 1'b0);

    // Random bursts on random instances.
    repeat (8) begin
      rg = $urandom_range(3);
      nb = $urandom_range(3, 1);
      for (int b = 0; b < nb; b++) sl_byte[rg][b] = 8'($urandom);
      for (int b = 0; b < nb; b++)
        run_xfer(rg, 8'($urandom), 1'(b == nb - 1), b, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
